// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the ALU interface. Accepts one instruction at a time over
//   a valid/ready handshake, decodes it, issues ALU ops for exactly one cycle,
//   and writes either the ALU result or an immediate back into a 4x8 register
//   file.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     instr_valid/instr_ready instruction handshake (ready only in IDLE)
//     instr[12:0]             ALU op: {0, op[2:0], rd, rs1, rs2, 3'bx}
//                             LDI   : {1, rd, 2'bx, imm[7:0]}
//     alu_en                  one-cycle ALU enable (ISSUE state)
//     alu_opcode[7:0]         {5'b0, op}, registered at accept
//     alu_in_1/alu_in_2[3:0]  low nibbles of rf[rs1]/rf[rs2], registered at accept
//     alu_out[7:0]            registered ALU result, sampled only in WB
//     result_valid/_data/_rd  write-back pulse, value and destination
//     dbg_addr/dbg_data       combinational register-file read port
module alu_issue_ctrl #(
  parameter int NREG = 4,
  parameter int IW   = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic          alu_en,
  output logic [7:0]    alu_opcode,
  output logic [3:0]    alu_in_1,
  output logic [3:0]    alu_in_2,
  input  logic [7:0]    alu_out,
  output logic          result_valid,
  output logic [7:0]    result_data,
  output logic [1:0]    result_rd,
  input  logic [1:0]    dbg_addr,
  output logic [7:0]    dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rf [NREG];

  // Decode of the incoming word (stage 0)
  logic        ldi_p0;
  logic [2:0]  op_p0;
  logic [1:0]  rd_p0;
  logic [1:0]  rs1_p0;
  logic [1:0]  rs2_p0;
  logic [7:0]  imm_p0;
  logic        accept_p0;
  logic        unused_instr;

  assign ldi_p0       = instr[12];
  assign op_p0        = instr[11:9];
  assign rd_p0        = ldi_p0 ? instr[11:10] : instr[8:7];
  assign rs1_p0       = instr[6:5];
  assign rs2_p0       = instr[4:3];
  assign imm_p0       = instr[7:0];
  assign unused_instr = ^instr[2:0];

  // Latched instruction context (stage 1), held until write-back
  logic        ldi_p1;
  logic [1:0]  rd_p1;
  logic [7:0]  imm_p1;
  logic        vld_p1;
  logic [7:0]  wb_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake/enable outputs
  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    alu_en       = 1'b0;
    vld_p1       = 1'b0;
    accept_p0    = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept_p0 = 1'b1;
          state_d   = ldi_p0 ? WB : ISSUE;
        end
      end
      ISSUE: begin
        alu_en  = 1'b1;
        state_d = WB;
      end
      WB: begin
        vld_p1  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALU result is only meaningful in WB; outside it the result port reads zero
  // so a stale, never-reset alu_out cannot leak out.
  assign wb_data      = ldi_p1 ? imm_p1 : alu_out;
  assign result_valid = vld_p1;
  assign result_data  = vld_p1 ? wb_data : 8'h00;
  assign result_rd    = vld_p1 ? rd_p1 : 2'd0;
  assign dbg_data     = rf[dbg_addr];

  // Accept: operands are read here, so rs==rd sees the pre-write value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldi_p1     <= 1'b0;
      rd_p1      <= 2'd0;
      imm_p1     <= 8'h00;
      alu_opcode <= 8'h00;
      alu_in_1   <= 4'h0;
      alu_in_2   <= 4'h0;
    end else if (accept_p0) begin
      ldi_p1 <= ldi_p0;
      rd_p1  <= rd_p0;
      imm_p1 <= imm_p0;
      if (!ldi_p0) begin
        alu_opcode <= {5'b00000, op_p0};
        alu_in_1   <= rf[rs1_p0][3:0];
        alu_in_2   <= rf[rs2_p0][3:0];
      end
    end
  end

  // Write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= 8'h00;
    end else if (vld_p1) begin
      rf[rd_p1] <= wb_data;
    end
  end

endmodule
